// File: rtl/jump_pkg.sv
// Shared constants and helpers for the jump/branch resolver.
package jump_pkg;

  localparam int unsigned JUMP_XLEN = 32;

  // Conditional branch funct3 encodings
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Link registers used as return-address hints
  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == LINK_X1) || (idx == LINK_X5);
  endfunction

endpackage

// File: rtl/jump_ras.sv
// Return-address stack: circular storage; overflow overwrites the oldest entry.
module jump_ras
  import jump_pkg::*;
#(
  parameter int unsigned XLEN      = JUMP_XLEN,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_vld
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   ptr;     // next free slot
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - 1'b1;
  assign ras_vld = (cnt != '0);
  assign ras_top = ras_vld ? stack[top_idx] : '0;

  // Stack storage, pointer and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (push && pop && ras_vld) begin
      // Simultaneous pop+push replaces the top in place
      stack[top_idx] <= push_data;
    end else if (push) begin
      stack[ptr] <= push_data;
      ptr        <= ptr + 1'b1;
      if (cnt != CNT_FULL) begin
        cnt <= cnt + 1'b1;
      end
    end else if (pop && ras_vld) begin
      ptr <= top_idx;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/jump_branch_unit.sv
// Execute-stage JAL/JALR/branch resolver with mispredict redirect and RAS.
// Optional feature macro: JUMP_MISALIGN_TRAP_EN (trap on taken target with bit 1 set).
module jump_branch_unit
  import jump_pkg::*;
#(
  parameter int unsigned XLEN      = JUMP_XLEN,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic            in_br,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rd_idx,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_addr,
  input  logic            kill,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic            out_wb_en,
  output logic [XLEN-1:0] out_wb_data,
  output logic            out_flush,
  output logic [XLEN-1:0] out_real_addr,
  output logic            out_trap,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_vld
);

  logic            accept;
  logic [XLEN-1:0] link_val;
  logic [XLEN-1:0] target;
  logic            cond;
  logic            taken;
  logic            trap_c;
  logic            flush_c;
  logic            wb_en_c;
  logic [XLEN-1:0] real_c;
  logic            rd_link;
  logic            rs1_link;
  logic            ras_push;
  logic            ras_pop;

  assign in_rdy = ~out_vld | out_rdy;
  assign accept = in_vld & in_rdy & ~kill;

  // Resolve target, condition, redirect and write-back for the incoming op
  always_comb begin
    link_val = in_pc + XLEN'(4);
    target   = in_pc + in_imm;
    if (in_jalr) begin
      target = (in_rs1 + in_imm) & ~XLEN'(1);
    end

    cond = 1'b0;
    case (in_funct3)
      BR_BEQ:  cond = (in_rs1 == in_rs2);
      BR_BNE:  cond = (in_rs1 != in_rs2);
      BR_BLT:  cond = ($signed(in_rs1) < $signed(in_rs2));
      BR_BGE:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      BR_BLTU: cond = (in_rs1 < in_rs2);
      BR_BGEU: cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase

    taken = in_jal | in_jalr | (in_br & cond);
    real_c = taken ? target : link_val;

`ifdef JUMP_MISALIGN_TRAP_EN
    trap_c = taken & target[1];
`else
    trap_c = 1'b0;
`endif

    flush_c = ((taken != in_pred_taken) || (taken && (target != in_pred_addr))) && !trap_c;
    wb_en_c = (in_jal | in_jalr) & (in_rd_idx != 5'd0) & ~trap_c;

    rd_link  = (in_jal | in_jalr) & is_link(in_rd_idx);
    rs1_link = is_link(in_rs1_idx);
    ras_push = accept & rd_link & ~trap_c;
    ras_pop  = accept & in_jalr & rs1_link & ~(rd_link & (in_rd_idx == in_rs1_idx)) & ~trap_c;
  end

  // Output register: kill drops it, accept loads it, consumption empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld       <= 1'b0;
      out_wb_en     <= 1'b0;
      out_wb_data   <= '0;
      out_flush     <= 1'b0;
      out_real_addr <= '0;
      out_trap      <= 1'b0;
    end else if (kill) begin
      out_vld   <= 1'b0;
      out_wb_en <= 1'b0;
      out_flush <= 1'b0;
      out_trap  <= 1'b0;
    end else if (accept) begin
      out_vld       <= 1'b1;
      out_wb_en     <= wb_en_c;
      out_wb_data   <= link_val;
      out_flush     <= flush_c;
      out_real_addr <= real_c;
      out_trap      <= trap_c;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  jump_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_val),
    .ras_top   (ras_top),
    .ras_vld   (ras_vld)
  );

endmodule

// File: tb/tb_jump_branch_unit.sv
// Directed self-checking bench for jump_branch_unit (RAS_DEPTH = 4).
module tb_jump_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, in_rdy, in_jal, in_jalr, in_br;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_addr;
  logic [4:0]  in_rs1_idx, in_rd_idx;
  logic        in_pred_taken, kill;
  logic        out_vld, out_rdy, out_wb_en, out_flush, out_trap, ras_vld;
  logic [31:0] out_wb_data, out_real_addr, ras_top;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jump_branch_unit #(
    .XLEN      (32),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .in_jal        (in_jal),
    .in_jalr       (in_jalr),
    .in_br         (in_br),
    .in_funct3     (in_funct3),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rs1_idx    (in_rs1_idx),
    .in_rd_idx     (in_rd_idx),
    .in_pred_taken (in_pred_taken),
    .in_pred_addr  (in_pred_addr),
    .kill          (kill),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_wb_en     (out_wb_en),
    .out_wb_data   (out_wb_data),
    .out_flush     (out_flush),
    .out_real_addr (out_real_addr),
    .out_trap      (out_trap),
    .ras_top       (ras_top),
    .ras_vld       (ras_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op for a single cycle, then sample #1 after the capturing edge.
  task automatic issue(input logic jal, input logic jalr, input logic br, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [4:0] rs1_idx,
                       input logic [4:0] rd_idx, input logic pt, input logic [31:0] pa);
    in_jal        = jal;
    in_jalr       = jalr;
    in_br         = br;
    in_funct3     = f3;
    in_pc         = pc;
    in_imm        = imm;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_rs1_idx    = rs1_idx;
    in_rd_idx     = rd_idx;
    in_pred_taken = pt;
    in_pred_addr  = pa;
    in_vld        = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  logic [7:0]  mask_eq, mask_lt;
  logic [31:0] held;
  logic        tk;

  initial begin
    rst = 1'b1;
    in_vld = 1'b0; in_jal = 1'b0; in_jalr = 1'b0; in_br = 1'b0; in_funct3 = 3'd0;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rs1_idx = '0; in_rd_idx = '0;
    in_pred_taken = 1'b0; in_pred_addr = '0; kill = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_ras_vld", {31'd0, ras_vld}, 32'd0);
    chk("rst_ras_top", ras_top, 32'd0);
    chk("rst_real_addr", out_real_addr, 32'd0);
    chk("rst_flush", {31'd0, out_flush}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_rdy", {31'd0, in_rdy}, 32'd1);

    // JAL with link rd=x1, predicted not taken
    issue(1, 0, 0, 3'd0, 32'h100, 32'h20, 0, 0, 5'd0, 5'd1, 0, 0);
    chk("jal_vld", {31'd0, out_vld}, 32'd1);
    chk("jal_flush", {31'd0, out_flush}, 32'd1);
    chk("jal_real", out_real_addr, 32'h120);
    chk("jal_wb_data", out_wb_data, 32'h104);
    chk("jal_wb_en", {31'd0, out_wb_en}, 32'd1);
    chk("jal_ras_top", ras_top, 32'h104);
    chk("jal_ras_vld", {31'd0, ras_vld}, 32'd1);

    // BLT -1 < 1 signed, correctly predicted
    issue(0, 0, 1, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 5'd2, 5'd3, 1, 32'h240);
    chk("blt_flush", {31'd0, out_flush}, 32'd0);
    chk("blt_real", out_real_addr, 32'h240);
    chk("blt_wb_en", {31'd0, out_wb_en}, 32'd0);
    // BLTU same operands: not taken, so the taken prediction is wrong
    issue(0, 0, 1, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 5'd2, 5'd3, 1, 32'h240);
    chk("bltu_flush", {31'd0, out_flush}, 32'd1);
    chk("bltu_real", out_real_addr, 32'h204);

    // All funct3 encodings: equal operands, then 3 vs 7
    mask_eq = 8'b1010_0001;
    mask_lt = 8'b0101_0010;
    for (int f = 0; f < 8; f++) begin
      issue(0, 0, 1, 3'(f), 32'h500, 32'h10, 32'd5, 32'd5, 5'd2, 5'd3, 0, 0);
      tk = mask_eq[f];
      chk($sformatf("eq_f%0d_real", f), out_real_addr, tk ? 32'h510 : 32'h504);
      chk($sformatf("eq_f%0d_flush", f), {31'd0, out_flush}, {31'd0, tk});
      issue(0, 0, 1, 3'(f), 32'h500, 32'h10, 32'd3, 32'd7, 5'd2, 5'd3, 0, 0);
      tk = mask_lt[f];
      chk($sformatf("lt_f%0d_real", f), out_real_addr, tk ? 32'h510 : 32'h504);
    end

    // Non-control op
    issue(0, 0, 0, 3'd0, 32'h400, 32'h80, 0, 0, 5'd1, 5'd1, 0, 0);
    chk("nop_flush", {31'd0, out_flush}, 32'd0);
    chk("nop_wb_en", {31'd0, out_wb_en}, 32'd0);
    chk("nop_real", out_real_addr, 32'h404);
    chk("nop_ras_top", ras_top, 32'h104);

    // JALR via x1, rd=x0: pops the single entry
    issue(0, 1, 0, 3'd0, 32'h300, 32'h0, 32'h203, 0, 5'd1, 5'd0, 0, 0);
    chk("jalr_real", out_real_addr, 32'h202);
    chk("jalr_flush", {31'd0, out_flush}, 32'd1);
    chk("jalr_wb_en", {31'd0, out_wb_en}, 32'd0);
    chk("jalr_ras_vld", {31'd0, ras_vld}, 32'd0);

    // Five pushes into a 4-deep RAS (one via x5), then five pops
    for (int k = 0; k < 5; k++) begin
      issue(1, 0, 0, 3'd0, 32'h0C + 32'(k) * 32'h10, 32'h100, 0, 0, 5'd0,
            (k == 2) ? 5'd5 : 5'd1, 1, 32'h10C + 32'(k) * 32'h10);
    end
    chk("ovf_ras_top", ras_top, 32'h50);
    chk("ovf_flush", {31'd0, out_flush}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      issue(0, 1, 0, 3'd0, 32'h600, 32'h0, 32'h700, 0, 5'd1, 5'd0, 0, 0);
      chk($sformatf("pop%0d_top", k), ras_top, (k < 3) ? 32'h40 - 32'(k) * 32'h10 : 32'd0);
      chk($sformatf("pop%0d_vld", k), {31'd0, ras_vld}, (k < 3) ? 32'd1 : 32'd0);
    end

    // Replace: push 0x10 via x5, then JALR rs1=x5 rd=x1 swaps top
    issue(1, 0, 0, 3'd0, 32'h0C, 32'h100, 0, 0, 5'd0, 5'd5, 0, 0);
    issue(0, 1, 0, 3'd0, 32'h70, 32'h0, 32'h900, 0, 5'd5, 5'd1, 0, 0);
    chk("repl_top", ras_top, 32'h74);
    issue(0, 1, 0, 3'd0, 32'h80, 32'h0, 32'h900, 0, 5'd1, 5'd0, 0, 0);
    chk("repl_pop_vld", {31'd0, ras_vld}, 32'd0);
    // rd == rs1 == x1: push only
    issue(0, 1, 0, 3'd0, 32'h80, 32'h0, 32'h900, 0, 5'd1, 5'd1, 0, 0);
    chk("same_push_top", ras_top, 32'h84);
    issue(0, 1, 0, 3'd0, 32'h90, 32'h0, 32'h900, 0, 5'd1, 5'd0, 0, 0);
    chk("same_pop_vld", {31'd0, ras_vld}, 32'd0);

    // Backpressure: result held while out_rdy is low
    issue(1, 0, 0, 3'd0, 32'h800, 32'h40, 0, 0, 5'd0, 5'd0, 0, 0);
    held = out_real_addr;
    chk("bp_first_real", held, 32'h840);
    out_rdy = 1'b0;
    in_jal = 1'b1; in_pc = 32'h900; in_imm = 32'h4; in_rd_idx = 5'd1; in_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_rdy", c), {31'd0, in_rdy}, 32'd0);
      chk($sformatf("bp%0d_vld", c), {31'd0, out_vld}, 32'd1);
      chk($sformatf("bp%0d_real", c), out_real_addr, 32'h840);
    end
    // Kill with the consumer ready: input must not be taken
    out_rdy = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    in_vld = 1'b0;
    chk("kill_vld", {31'd0, out_vld}, 32'd0);
    chk("kill_ras_vld", {31'd0, ras_vld}, 32'd0);

    // Misaligned target 0x102
    issue(1, 0, 0, 3'd0, 32'h100, 32'h2, 0, 0, 5'd0, 5'd1, 0, 0);
`ifdef JUMP_MISALIGN_TRAP_EN
    chk("mis_trap", {31'd0, out_trap}, 32'd1);
    chk("mis_flush", {31'd0, out_flush}, 32'd0);
    chk("mis_wb_en", {31'd0, out_wb_en}, 32'd0);
    chk("mis_ras_vld", {31'd0, ras_vld}, 32'd0);
`else
    chk("mis_trap", {31'd0, out_trap}, 32'd0);
    chk("mis_real", out_real_addr, 32'h102);
    chk("mis_flush", {31'd0, out_flush}, 32'd1);
    chk("mis_ras_top", ras_top, 32'h104);
`endif

    // Asynchronous reset mid-stream clears output and RAS immediately
    issue(1, 0, 0, 3'd0, 32'hA00, 32'h10, 0, 0, 5'd0, 5'd1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("arst_ras_vld", {31'd0, ras_vld}, 32'd0);
    chk("arst_ras_top", ras_top, 32'd0);
    chk("arst_real", out_real_addr, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
